// File: rtl/trajectory_if.sv
// Launch/step command bundle between a flight controller and the trajectory driver.
interface trajectory_if;
    logic       frame_tick;
    logic       launch;
    logic [9:0] launch_vx;
    logic       launch_dirx;
    logic [8:0] launch_vy;
    logic [8:0] launch_y;
    logic [1:0] dx;
    logic [1:0] dy;
    logic [9:0] vx;
    logic [8:0] vy;
    logic       busy;
    logic       done;

    modport master (
        output frame_tick, launch, launch_vx, launch_dirx, launch_vy, launch_y,
        input  dx, dy, vx, vy, busy, done
    );

    modport slave (
        input  frame_tick, launch, launch_vx, launch_dirx, launch_vy, launch_y,
        output dx, dy, vx, vy, busy, done
    );
endinterface

// File: rtl/trajectory_driver.sv
// Ballistic flight sequencer: one step pulse per frame tick, gravity applied after each step,
// shadow y tracked to detect the floor.
module trajectory_driver #(
    parameter int unsigned GRAVITY  = 1,
    parameter int unsigned VMAX     = 15,
    parameter int unsigned FLOOR_Y  = 479,
    parameter int unsigned PULSE_HI = 2,
    parameter int unsigned PULSE_LO = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    trajectory_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StWaitTick, StPulse, StGap, StDone} state_e;

    localparam logic [7:0]        HiLast = 8'(PULSE_HI - 1);
    localparam logic [7:0]        LoLast = 8'(PULSE_LO - 1);
    localparam logic signed [11:0] VmaxS = 12'(VMAX);
    localparam logic [9:0]        FloorY = 10'(FLOOR_Y);

    state_e            state;
    logic signed [9:0] vel;
    logic [9:0]        shadow_y;
    logic [9:0]        cap_vx;
    logic              cap_dirx;
    logic [7:0]        cnt;
    logic [1:0]        dx_q, dy_q;
    logic [9:0]        vx_q;
    logic [8:0]        vy_q;
    logic              busy_q, done_q;

    logic [9:0]         vel_mag;
    logic [8:0]         step_mag;
    logic signed [11:0] y_sum;
    logic [9:0]         y_next;
    logic signed [11:0] vel_inc;
    logic signed [9:0]  vel_next;

    always_comb begin
        vel_mag  = vel[9] ? 10'($unsigned(-vel)) : 10'($unsigned(vel));
        // Upward moves never carry the object above the top edge.
        step_mag = (vel[9] && (vel_mag > shadow_y)) ? shadow_y[8:0] : vel_mag[8:0];
        y_sum    = $signed({2'b00, shadow_y}) + $signed({{2{vel[9]}}, vel});
        if (y_sum < 12'sd0) begin
            y_next = 10'd0;
        end else if (y_sum > 12'sd1023) begin
            y_next = 10'd1023;
        end else begin
            y_next = y_sum[9:0];
        end
        vel_inc  = $signed({{2{vel[9]}}, vel}) + $signed(12'(GRAVITY));
        vel_next = (vel_inc > VmaxS) ? VmaxS[9:0] : vel_inc[9:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            vel      <= '0;
            shadow_y <= '0;
            cap_vx   <= '0;
            cap_dirx <= 1'b0;
            cnt      <= '0;
            dx_q     <= 2'b00;
            dy_q     <= 2'b00;
            vx_q     <= '0;
            vy_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.launch) begin
                        cap_vx   <= bus.launch_vx;
                        cap_dirx <= bus.launch_dirx;
                        vel      <= -$signed({1'b0, bus.launch_vy});
                        shadow_y <= {1'b0, bus.launch_y};
                        busy_q   <= 1'b1;
                        state    <= StWaitTick;
                    end
                end
                StWaitTick: begin
                    if (bus.frame_tick) begin
                        vx_q  <= cap_vx;
                        vy_q  <= step_mag;
                        dx_q  <= {1'b1, cap_dirx};
                        dy_q  <= {1'b1, ~vel[9]};
                        cnt   <= '0;
                        state <= StPulse;
                    end
                end
                StPulse: begin
                    if (cnt == HiLast) begin
                        dx_q[1] <= 1'b0;
                        dy_q[1] <= 1'b0;
                        cnt     <= '0;
                        state   <= StGap;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                StGap: begin
                    if (cnt == LoLast) begin
                        shadow_y <= y_next;
                        vel      <= vel_next;
                        if (y_next >= FloorY) begin
                            done_q <= 1'b1;
                            state  <= StDone;
                        end else begin
                            state <= StWaitTick;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                StDone: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.dx   = dx_q;
    assign bus.dy   = dy_q;
    assign bus.vx   = vx_q;
    assign bus.vy   = vy_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
